// File: rtl/game_pkg.sv
// Shared definitions for the shooter game-flow controller: state encoding
// and default timing/lives constants.
package game_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_TITLE      = 2'd0,
    ST_PLAY       = 2'd1,
    ST_WAVE_CLEAR = 2'd2,
    ST_GAME_OVER  = 2'd3
  } game_state_t;

  localparam int unsigned LIVES_INIT_DEF   = 3;
  localparam int unsigned CLEAR_FRAMES_DEF = 60;
  localparam int unsigned OVER_FRAMES_DEF  = 120;

endpackage

// File: rtl/frame_delay_counter.sv
// Counts frame_tick strobes while not cleared; done pulses on the tick that
// brings the count to terminal+1, then the count restarts from zero.
module frame_delay_counter #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk25,
  input  logic             reset,
  input  logic             clear,
  input  logic             frame_tick,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  assign done = frame_tick & ~clear & (count == terminal);

  always_ff @(posedge clk25) begin
    if (reset || clear || done) begin
      count <= '0;
    end else if (frame_tick) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: title -> play -> wave-clear -> game-over, with
// respawn pulses and wave/lives/score bookkeeping. All outputs registered.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned ENEMY_COUNT  = 4,
  parameter int unsigned LIVES_INIT   = LIVES_INIT_DEF,
  parameter int unsigned LIVES_W      = 2,
  parameter int unsigned SCORE_W      = 16,
  parameter int unsigned WAVE_W       = 4,
  parameter int unsigned CLEAR_FRAMES = CLEAR_FRAMES_DEF,
  parameter int unsigned OVER_FRAMES  = OVER_FRAMES_DEF
) (
  input  logic                   clk25,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   btn_fire,
  input  logic [ENEMY_COUNT-1:0] enemy_alive,
  input  logic [ENEMY_COUNT-1:0] enemy_kill,
  input  logic                   player_hit,
  input  logic                   enemy_breach,
  output logic [STATE_W-1:0]     state,
  output logic                   play_en,
  output logic                   enemy_respawn,
  output logic [WAVE_W-1:0]      wave,
  output logic [LIVES_W-1:0]     lives,
  output logic [SCORE_W-1:0]     score
);

  localparam int unsigned MAX_FRAMES = (CLEAR_FRAMES > OVER_FRAMES) ? CLEAR_FRAMES : OVER_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam int unsigned PC_W       = $clog2(ENEMY_COUNT + 1);
  localparam int unsigned SUM_W      = SCORE_W + PC_W;
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES - 1);

  function automatic logic [PC_W-1:0] popcount(input logic [ENEMY_COUNT-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < ENEMY_COUNT; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  game_state_t        state_q, state_d;
  logic [WAVE_W-1:0]  wave_d;
  logic [LIVES_W-1:0] lives_d;
  logic [SCORE_W-1:0] score_d, score_sat;
  logic [SUM_W-1:0]   score_sum;
  logic               armed_q, armed_d;
  logic               respawn_d;
  logic               btn_fire_q;
  logic               fire_rise;
  logic               delay_clear;
  logic               delay_done;
  logic [CNT_W-1:0]   delay_last;

  assign state     = state_q;
  assign fire_rise = btn_fire & ~btn_fire_q;

  // Held at zero outside the timed states so each timeout starts from a fresh count.
  assign delay_clear = (state_q == ST_TITLE) || (state_q == ST_PLAY);
  assign delay_last  = (state_q == ST_GAME_OVER) ? OVER_LAST : CLEAR_LAST;

  frame_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk25      (clk25),
    .reset      (reset),
    .clear      (delay_clear),
    .frame_tick (frame_tick),
    .terminal   (delay_last),
    .done       (delay_done)
  );

  assign score_sum = SUM_W'(score) + SUM_W'(popcount(enemy_kill));
  assign score_sat = (score_sum[SUM_W-1:SCORE_W] != '0) ? '1 : score_sum[SCORE_W-1:0];

  always_comb begin
    state_d   = state_q;
    wave_d    = wave;
    lives_d   = lives;
    score_d   = score;
    armed_d   = armed_q;
    respawn_d = 1'b0;
    unique case (state_q)
      ST_TITLE: begin
        if (fire_rise) begin
          state_d   = ST_PLAY;
          respawn_d = 1'b1;
          wave_d    = WAVE_W'(1);
          lives_d   = LIVES_W'(LIVES_INIT);
          score_d   = '0;
          armed_d   = 1'b0;
        end
      end
      ST_PLAY: begin
        score_d = score_sat;
        // Arming waits for a non-empty alive vector so the stale all-dead
        // snapshot right after a respawn does not look like a cleared wave.
        if (enemy_alive != '0) armed_d = 1'b1;
        if (enemy_breach) begin
          lives_d = '0;
          state_d = ST_GAME_OVER;
        end else if (player_hit) begin
          if (lives == LIVES_W'(1)) begin
            lives_d = '0;
            state_d = ST_GAME_OVER;
          end else begin
            lives_d = lives - LIVES_W'(1);
          end
        end else if (armed_q && (enemy_alive == '0)) begin
          state_d = ST_WAVE_CLEAR;
        end
      end
      ST_WAVE_CLEAR: begin
        if (delay_done) begin
          state_d   = ST_PLAY;
          respawn_d = 1'b1;
          armed_d   = 1'b0;
          if (wave != '1) wave_d = wave + WAVE_W'(1);
        end
      end
      ST_GAME_OVER: begin
        if (delay_done) state_d = ST_TITLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q       <= ST_TITLE;
      play_en       <= 1'b0;
      enemy_respawn <= 1'b0;
      wave          <= '0;
      lives         <= LIVES_W'(LIVES_INIT);
      score         <= '0;
      armed_q       <= 1'b0;
      btn_fire_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      play_en       <= (state_d == ST_PLAY);
      enemy_respawn <= respawn_d;
      wave          <= wave_d;
      lives         <= lives_d;
      score         <= score_d;
      armed_q       <= armed_d;
      btn_fire_q    <= btn_fire;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised and directed stimulus for game_sequencer, checked every cycle
// against a behavioural model of the game rules.
module tb_game_sequencer;

  logic clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  logic       reset, frame_tick, btn_fire, player_hit, enemy_breach;
  logic [3:0] enemy_alive, enemy_kill;

  logic [1:0]  state, state_s;
  logic        play_en, play_en_s, enemy_respawn, enemy_respawn_s;
  logic [3:0]  wave, wave_s;
  logic [1:0]  lives, lives_s;
  logic [15:0] score;
  logic [1:0]  score_s;

  game_sequencer dut (
    .clk25(clk25), .reset(reset), .frame_tick(frame_tick), .btn_fire(btn_fire),
    .enemy_alive(enemy_alive), .enemy_kill(enemy_kill), .player_hit(player_hit),
    .enemy_breach(enemy_breach), .state(state), .play_en(play_en),
    .enemy_respawn(enemy_respawn), .wave(wave), .lives(lives), .score(score)
  );

  game_sequencer #(.SCORE_W(2)) dut_s (
    .clk25(clk25), .reset(reset), .frame_tick(frame_tick), .btn_fire(btn_fire),
    .enemy_alive(enemy_alive), .enemy_kill(enemy_kill), .player_hit(player_hit),
    .enemy_breach(enemy_breach), .state(state_s), .play_en(play_en_s),
    .enemy_respawn(enemy_respawn_s), .wave(wave_s), .lives(lives_s), .score(score_s)
  );

  localparam int M_TITLE = 0, M_PLAY = 1, M_CLEAR = 2, M_OVER = 3;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: game rules in plain integer arithmetic.
  int m_state = M_TITLE, m_wave = 0, m_lives = 3, m_score = 0, m_score2 = 0;
  int m_frames = 0, m_armed = 0, m_fire_prev = 1, m_resp = 0;
  logic prev_resp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    int kills;
    bit rise;
    if (reset) begin
      m_state = M_TITLE; m_wave = 0; m_lives = 3; m_score = 0; m_score2 = 0;
      m_frames = 0; m_armed = 0; m_fire_prev = 1; m_resp = 0;
      return;
    end
    rise = btn_fire && (m_fire_prev == 0);
    m_fire_prev = btn_fire;
    m_resp = 0;
    case (m_state)
      M_TITLE: if (rise) begin
        m_state = M_PLAY; m_resp = 1; m_wave = 1; m_lives = 3;
        m_score = 0; m_score2 = 0; m_armed = 0;
      end
      M_PLAY: begin
        kills = $countones(enemy_kill);
        m_score  = min_i(m_score + kills, 65535);
        m_score2 = min_i(m_score2 + kills, 3);
        if (enemy_breach) begin
          m_lives = 0; m_state = M_OVER; m_frames = 0;
        end else if (player_hit) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin m_state = M_OVER; m_frames = 0; end
        end else if (m_armed != 0 && enemy_alive == 0) begin
          m_state = M_CLEAR; m_frames = 0;
        end
        if (enemy_alive != 0) m_armed = 1;
      end
      M_CLEAR: if (frame_tick) begin
        m_frames++;
        if (m_frames == 60) begin
          m_state = M_PLAY; m_resp = 1; m_armed = 0; m_frames = 0;
          m_wave = min_i(m_wave + 1, 15);
        end
      end
      default: if (frame_tick) begin
        m_frames++;
        if (m_frames == 120) begin m_state = M_TITLE; m_frames = 0; end
      end
    endcase
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_state));
    check("play_en", 32'(play_en), 32'(m_state == M_PLAY));
    check("respawn", 32'(enemy_respawn), 32'(m_resp));
    check("wave", 32'(wave), 32'(m_wave));
    check("lives", 32'(lives), 32'(m_lives));
    check("score", 32'(score), 32'(m_score));
    check("s_state", 32'(state_s), 32'(m_state));
    check("s_play_en", 32'(play_en_s), 32'(m_state == M_PLAY));
    check("s_respawn", 32'(enemy_respawn_s), 32'(m_resp));
    check("s_wave", 32'(wave_s), 32'(m_wave));
    check("s_lives", 32'(lives_s), 32'(m_lives));
    check("s_score", 32'(score_s), 32'(m_score2));
    check("respawn_twice", 32'(enemy_respawn & prev_resp), 32'd0);
    prev_resp = enemy_respawn;
  endtask

  task automatic step(input bit r, input bit f, input bit t, input logic [3:0] al,
                      input logic [3:0] k, input bit h, input bit b);
    reset = r; btn_fire = f; frame_tick = t; enemy_alive = al; enemy_kill = k;
    player_hit = h; enemy_breach = b;
    @(posedge clk25);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run_ticks(input int n, input bit toggle_fire);
    for (int i = 0; i < n; i++) step(0, toggle_fire & i[0], 1, 4'h0, 4'hF, 1, 1);
  endtask

  initial begin
    // Fire held through reset must not start a game.
    repeat (3) step(1, 1, 0, 4'h0, 4'h0, 0, 0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_wave", 32'(wave), 32'd0);
    repeat (3) step(0, 1, 0, 4'h0, 4'h0, 0, 0);
    check("held_no_start", 32'(state), 32'd0);
    step(0, 0, 0, 4'h0, 4'h0, 0, 0);
    step(0, 1, 0, 4'h0, 4'h0, 0, 0);
    check("start_state", 32'(state), 32'd1);
    check("start_resp", 32'(enemy_respawn), 32'd1);
    check("start_wave", 32'(wave), 32'd1);
    check("start_play_en", 32'(play_en), 32'd1);

    // Kills with a stale all-dead vector: no wave clear, score counts.
    step(0, 1, 0, 4'h0, 4'b1011, 0, 0);
    check("score_3", 32'(score), 32'd3);
    check("resp_one_cycle", 32'(enemy_respawn), 32'd0);
    check("sat2_a", 32'(score_s), 32'd3);
    step(0, 1, 0, 4'h0, 4'b0100, 0, 0);
    check("score_4", 32'(score), 32'd4);
    check("sat2_b", 32'(score_s), 32'd3);
    check("unarmed_play", 32'(state), 32'd1);

    step(0, 0, 0, 4'hF, 4'h0, 0, 0);
    step(0, 0, 0, 4'h0, 4'h0, 0, 0);
    check("enter_clear", 32'(state), 32'd2);
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0, 4'h0, 4'hF, 1, 1);
      step(0, 0, 1, 4'h0, 4'hF, 1, 1);
      if (i == 58) check("clear_59", 32'(state), 32'd2);
    end
    check("clear_done", 32'(state), 32'd1);
    check("wave_2", 32'(wave), 32'd2);
    check("clear_resp", 32'(enemy_respawn), 32'd1);

    // Three hits end the game; score held through GAME_OVER and TITLE.
    step(0, 0, 0, 4'hF, 4'h0, 0, 0);
    step(0, 0, 0, 4'hF, 4'h0, 1, 0);
    check("lives_2", 32'(lives), 32'd2);
    step(0, 0, 0, 4'hF, 4'h0, 1, 0);
    check("lives_1", 32'(lives), 32'd1);
    step(0, 0, 0, 4'hF, 4'h0, 1, 0);
    check("lives_0", 32'(lives), 32'd0);
    check("over", 32'(state), 32'd3);
    run_ticks(119, 1);
    check("over_119", 32'(state), 32'd3);
    run_ticks(1, 1);
    check("title_again", 32'(state), 32'd0);
    check("score_held", 32'(score), 32'd4);

    // Breach, hit and all-dead together: game over.
    step(0, 0, 0, 4'h0, 4'h0, 0, 0);
    step(0, 1, 0, 4'h0, 4'h0, 0, 0);
    step(0, 0, 0, 4'hF, 4'h0, 0, 0);
    step(0, 0, 0, 4'h0, 4'h0, 1, 1);
    check("prio_state", 32'(state), 32'd3);
    check("prio_lives", 32'(lives), 32'd0);
    run_ticks(120, 0);

    // Reset in the middle of WAVE_CLEAR.
    step(0, 1, 0, 4'h0, 4'h0, 0, 0);
    step(0, 0, 0, 4'hF, 4'h0, 0, 0);
    step(0, 0, 0, 4'h0, 4'h0, 0, 0);
    check("clear_again", 32'(state), 32'd2);
    run_ticks(30, 0);
    step(1, 0, 1, 4'h0, 4'h0, 0, 0);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_wave", 32'(wave), 32'd0);
    check("midrst_score", 32'(score), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 4'h0, 4'h0, 0, 0);
      check("midrst_no_resp", 32'(enemy_respawn), 32'd0);
    end

    // Wave counter saturation.
    step(0, 1, 0, 4'h0, 4'h0, 0, 0);
    for (int w = 0; w < 16; w++) begin
      step(0, 0, 0, 4'hF, 4'h0, 0, 0);
      step(0, 0, 0, 4'h0, 4'h0, 0, 0);
      run_ticks(60, 0);
    end
    check("wave_sat", 32'(wave), 32'd15);

    // Random soak.
    for (int i = 0; i < 5000; i++) begin
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
           4'($urandom & $urandom & $urandom),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 149) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
